// File: rtl/mucosmic_daq_pkg.sv
// Shared types and widths for the trigger timestamper.
// Defining PULSE_WIDTH_EN widens the event word by a 16-bit pulse-width field.
package mucosmic_daq_pkg;

    typedef enum logic [1:0] {ARMED, DEAD, WAIT_LOW} ts_state_t;

    localparam int TS_W = 32;
    localparam int DT_W = 16;
    localparam int PW_W = 16;

`ifdef PULSE_WIDTH_EN
    localparam int PW_EXT_W = PW_W;
`else
    localparam int PW_EXT_W = 0;
`endif

    function automatic int ev_width(input int ts_w);
        return ts_w + PW_EXT_W;
    endfunction

endpackage

// File: rtl/trigger_timestamper_if.sv
// Event readout stream: the timestamper is master, the readout logic is slave.
// A word transfers on every cycle where ev_valid and ev_ready are both high.
interface trigger_timestamper_if #(
    parameter int DW = 32
);
    logic [DW-1:0] ev_data;
    logic          ev_valid;
    logic          ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ts_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is combinational from the head slot.
// A push while full is accepted only when a pop happens in the same cycle.
module ts_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_rd_en = pop & ~empty;
    // When full, the write lands in the slot the pop is vacating this same edge.
    assign w_wr_en = push & (~full | w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign level = r_wr_ptr - r_rd_ptr;
    assign empty = (level == '0);
    assign full  = level[AW];
    assign dout  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/trigger_timestamper.sv
// Turns trigger rising edges into timestamped events with dead time, buffered in a FWFT FIFO.
// Latency edge->ev_valid is 2 clocks (pulse length + 2 with PULSE_WIDTH_EN); drops and counts when full.
module trigger_timestamper
    import mucosmic_daq_pkg::*;
#(
    parameter int TS_WIDTH  = TS_W,
    parameter int DEPTH     = 16,
    parameter int DT_WIDTH  = DT_W,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   trigger_in,
    input  logic [DT_WIDTH-1:0]    dead_time,
    trigger_timestamper_if.master  ev,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_WIDTH-1:0]   event_cnt,
    output logic [CNT_WIDTH-1:0]   drop_cnt
);
    localparam int EV_W = ev_width(TS_WIDTH);

    ts_state_t           r_state;
    ts_state_t           w_state_nxt;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic [DT_WIDTH-1:0] w_dt_nxt;
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_cap_ts;
    logic                r_trig_q;
    logic                r_push;
    logic                w_edge;
    logic                w_capture;
    logic                w_evt_done;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [EV_W-1:0]     w_din;
    logic [EV_W-1:0]     w_dout;

    assign w_edge = trigger_in & ~r_trig_q;

    always_comb begin
        w_state_nxt = r_state;
        w_dt_nxt    = r_dt_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ARMED: begin
                if (w_edge && enable) begin
                    w_state_nxt = DEAD;
                    w_dt_nxt    = dead_time;
                    w_capture   = 1'b1;
                end
            end
            DEAD: begin
                if (r_dt_cnt == '0) begin
                    w_state_nxt = trigger_in ? WAIT_LOW : ARMED;
                end else begin
                    w_dt_nxt = r_dt_cnt - 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!trigger_in) w_state_nxt = ARMED;
            end
            default: w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARMED;
            r_dt_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dt_cnt <= w_dt_nxt;
        end
    end

`ifdef PULSE_WIDTH_EN
    logic            r_meas;
    logic [PW_W-1:0] r_pw;

    // The event is complete once the trigger is first seen low after the accepted edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meas <= 1'b0;
            r_pw   <= '0;
        end else if (w_capture) begin
            r_meas <= 1'b1;
            r_pw   <= PW_W'(1);
        end else if (r_meas) begin
            if (!trigger_in)     r_meas <= 1'b0;
            else if (r_pw != '1) r_pw   <= r_pw + 1'b1;
        end
    end

    assign w_evt_done = r_meas & ~trigger_in;
    assign w_din      = {r_pw, r_cap_ts};
`else
    assign w_evt_done = w_capture;
    assign w_din      = r_cap_ts;
`endif

    assign w_pop  = ev.ev_ready & ~w_empty;
    assign w_push = r_push & (~w_full | w_pop);
    assign w_drop = r_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts      <= '0;
            r_trig_q  <= 1'b0;
            r_cap_ts  <= '0;
            r_push    <= 1'b0;
            event_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_trig_q <= trigger_in;
            r_push   <= w_evt_done;
            if (w_capture) r_cap_ts <= r_ts;
            if (w_push) event_cnt <= event_cnt + 1'b1;
            if (w_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    ts_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .level (fifo_level)
    );

    assign ev.ev_data  = w_dout;
    assign ev.ev_valid = ~w_empty;
endmodule

// File: tb/tb_trigger_timestamper.sv
// Directed bench for trigger_timestamper: edge timing, dead time, FIFO full/drop, wrap, reset.
module tb_trigger_timestamper;
    import mucosmic_daq_pkg::*;

    localparam int DEPTH = 16;
    localparam int EV_W  = ev_width(32);
`ifdef PULSE_WIDTH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic        trigger_in = 1'b0;
    logic [15:0] dead_time  = '0;
    logic [4:0]  fifo_level;
    logic [31:0] event_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] m_ts;
    logic [31:0] t_save;
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    trigger_timestamper_if #(.DW(EV_W)) ev_if ();

    trigger_timestamper #(
        .TS_WIDTH  (32),
        .DEPTH     (DEPTH),
        .DT_WIDTH  (16),
        .CNT_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .trigger_in (trigger_in),
        .dead_time  (dead_time),
        .ev         (ev_if),
        .fifo_level (fifo_level),
        .event_cnt  (event_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ts <= '0;
        else        m_ts <= m_ts + 32'd1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        trigger_in = 1'b0;
        ev_if.ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ts(input logic [31:0] t);
        int n;
        n = 0;
        while (m_ts != t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_ts != t) check_val("wait_ts", 64'(m_ts), 64'(t));
    endtask

    task automatic pulse(input int len);
        trigger_in = 1'b1;
        repeat (len) @(negedge clk);
        trigger_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        while (exp_q.size() > 0) begin
            w = 0;
            while (ev_if.ev_valid !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check_val({tag, "_vld"}, 64'(ev_if.ev_valid), 64'd1);
            if (ev_if.ev_valid !== 1'b1) begin
                exp_q.delete();
            end else begin
                check_val({tag, "_dat"}, 64'(ev_if.ev_data[31:0]), 64'(exp_q.pop_front()));
                ev_if.ev_ready = 1'b1;
                @(negedge clk);
                ev_if.ev_ready = 1'b0;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ev_if.ev_ready = 1'b0;

        // Single pulse at ts=100
        do_reset();
        check_val("rst_valid", 64'(ev_if.ev_valid), 64'd0);
        check_val("rst_data",  64'(ev_if.ev_data),  64'd0);
        check_val("rst_level", 64'(fifo_level),     64'd0);
        check_val("rst_evcnt", 64'(event_cnt),      64'd0);
        check_val("rst_drop",  64'(drop_cnt),       64'd0);
        check_val("rst_state", 64'(dut.r_state),    64'(ARMED));
        enable = 1'b1;
        dead_time = 16'd5;
        wait_ts(32'd100);
        pulse(1);
        repeat (LAT - 2) @(negedge clk);
        check_val("t1_early_valid", 64'(ev_if.ev_valid), 64'd0);
        @(negedge clk);
        check_val("t1_ts",    64'(m_ts), 64'(100 + LAT));
        check_val("t1_valid", 64'(ev_if.ev_valid), 64'd1);
        check_val("t1_data",  64'(ev_if.ev_data[31:0]), 64'd100);
        check_val("t1_evcnt", 64'(event_cnt), 64'd1);

        // Edge inside dead time is ignored
        do_reset();
        dead_time = 16'd5;
        wait_ts(32'd100);
        pulse(1);
        wait_ts(32'd103);
        pulse(1);
        wait_ts(32'd110);
        pulse(1);
        repeat (4) @(negedge clk);
        check_val("t2_evcnt", 64'(event_cnt), 64'd2);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd110);
        drain("t2");

        // Long trigger: one event, WAIT_LOW until the fall
        do_reset();
        dead_time = 16'd2;
        wait_ts(32'd50);
        trigger_in = 1'b1;
        repeat (25) @(negedge clk);
        check_val("t3_state_wait", 64'(dut.r_state), 64'(WAIT_LOW));
        repeat (25) @(negedge clk);
        trigger_in = 1'b0;
        repeat (5) @(negedge clk);
        check_val("t3_state_armed", 64'(dut.r_state), 64'(ARMED));
        check_val("t3_evcnt", 64'(event_cnt), 64'd1);
        check_val("t3_level", 64'(fifo_level), 64'd1);
        exp_q.push_back(32'd50);
        drain("t3");

        // Overfill: DEPTH+3 pulses with no readout
        do_reset();
        dead_time = 16'd0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            if (k < DEPTH) exp_q.push_back(m_ts);
            pulse(1);
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_val("t4_level", 64'(fifo_level), 64'(DEPTH));
        check_val("t4_drop",  64'(drop_cnt),   64'd3);
        check_val("t4_evcnt", 64'(event_cnt),  64'(DEPTH));

        // Push while full coinciding with a pop
        t_save = m_ts;
        pulse(1);
        repeat (LAT - 2) @(negedge clk);
        check_val("t5_head", 64'(ev_if.ev_data[31:0]), 64'(exp_q.pop_front()));
        ev_if.ev_ready = 1'b1;
        @(negedge clk);
        ev_if.ev_ready = 1'b0;
        exp_q.push_back(t_save);
        @(negedge clk);
        check_val("t5_level", 64'(fifo_level), 64'(DEPTH));
        check_val("t5_drop",  64'(drop_cnt),   64'd3);
        check_val("t5_evcnt", 64'(event_cnt),  64'(DEPTH + 1));
        drain("t4");
        check_val("t4_empty", 64'(fifo_level), 64'd0);

        // Timestamp wrap, then reset in the middle of DEAD
        do_reset();
        dead_time = 16'd5;
        @(negedge clk);
        force dut.r_ts = 32'hFFFF_FFFE;
        #1;
        release dut.r_ts;
        repeat (3) @(negedge clk);
        pulse(1);
        repeat (LAT - 1) @(negedge clk);
        check_val("t6_valid", 64'(ev_if.ev_valid), 64'd1);
        check_val("t6_data",  64'(ev_if.ev_data[31:0]), 64'd1);
        check_val("t6_state_dead", 64'(dut.r_state), 64'(DEAD));
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid", 64'(ev_if.ev_valid), 64'd0);
        check_val("t6_rst_data",  64'(ev_if.ev_data),  64'd0);
        check_val("t6_rst_level", 64'(fifo_level),     64'd0);
        check_val("t6_rst_evcnt", 64'(event_cnt),      64'd0);
        check_val("t6_rst_state", 64'(dut.r_state),    64'(ARMED));
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PULSE_WIDTH_EN
        // 7-cycle pulse reports its width
        repeat (3) @(negedge clk);
        t_save = m_ts;
        pulse(7);
        repeat (2) @(negedge clk);
        check_val("pw_valid", 64'(ev_if.ev_valid), 64'd1);
        check_val("pw_width", 64'(ev_if.ev_data[EV_W-1:32]), 64'd7);
        check_val("pw_ts",    64'(ev_if.ev_data[31:0]), 64'(t_save));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
